icache_ctrl: RTL
================

// Module: icache_ctrl
// PURPOSE
//  Direct-mapped, read-only instruction cache sitting between the PC register and off-chip instruction memory.
//  Consumes the fetch address each cycle and returns the instruction.
//  On a miss, drives stall_o, which feeds the PC stall input, and refills a line over a req/ack memory handshake.
//  Hit path is single-cycle, with no write-back (instruction memory is never written).
// PARAMETERS
//  NUM_LINES   32  number of cache lines; power of 2, >= 2
//  LINE_WORDS  8   32-bit words per line; power of 2, >= 2; line = LINE_WORDS*32 bits
// PORTS
//  clk_i        in   1              clock, rising edge
//  rst_i        in   1              reset, asynchronous, active-high
//  req_i        in   1              fetch request valid (CPU started)
//  addr_i       in   32             fetch address (PC); bits[1:0] ignored
//  flush_i      in   1              invalidate all lines
//  instr_o      out  32             fetched instruction
//  stall_o      out  1              fetch not satisfied this cycle; holds PC
//  mem_req_o    out  1              line refill request
//  mem_addr_o   out  32             line-aligned refill address
//  mem_data_i   in   LINE_WORDS*32  refill line; word 0 in bits[31:0]
//  mem_ack_i    in   1              refill data valid; 1-cycle pulse
// BEHAVIOUR
//  - Address split:
//    - OFF = addr_i[log2(LINE_WORDS)+1:2]
//    - IDX = next log2(NUM_LINES) bits
//    - TAG = remaining upper bits
//  - Storage: per line, valid bit + tag + data.
//  - Reset (async):
//    - all valid = 0, state = IDLE
//    - mem_req_o = 0, mem_addr_o = 0, stall_o = 0, instr_o = 0
//    - mem_req_o drops immediately, even mid-miss
//  - hit = req_i & valid[IDX] & (tag[IDX] == TAG); evaluated combinationally in IDLE only.
//  - Outputs:
//    - instr_o = line[IDX] word OFF when IDLE & hit, else 0.
//    - stall_o = req_i & ~(IDLE & hit). Also 1 in REQ and FILL regardless of req_i.
//    - req_i = 0 in IDLE: stall_o = 0, no miss started.
//  - FSM:
//    - IDLE -> REQ on req_i & ~hit. Latch line address {TAG, IDX, 0...}; mem_req_o = 1 from the next cycle.
//    - REQ: hold mem_req_o = 1 and mem_addr_o stable until mem_ack_i is sampled high. Then capture mem_data_i -> FILL.
//    - FILL: write data, tag, valid = 1 into the latched IDX; stall_o = 1; mem_req_o = 0. Next state IDLE.
//    - After FILL, the same address hits in IDLE. Miss penalty = 3 + (ack delay) cycles of stall_o.
//  - addr_i changing during REQ/FILL: fill completes for the latched address; the new address is looked up on return to IDLE.
//  - mem_ack_i in IDLE or FILL: ignored.
//  - Flush:
//    - flush_i in IDLE: all valid cleared at the edge; stall_o forced 1 that cycle; no miss started.
//    - flush_i in REQ/FILL: latched as pending. On the FILL->IDLE edge all valid are cleared, including the line just filled.
//  - Reset mid-miss: state to IDLE, pending flush cleared, in-flight ack discarded.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
//    - Reset to 0; wrap at 2^32.
//    - hit_cnt_o increments on each IDLE cycle with req_i & hit.
//    - miss_cnt_o increments on each IDLE->REQ transition.
//  Not defined: both ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Cold miss: req_i=1, addr 0x40, ack 4 cycles after mem_req_o rises.
//     -> mem_addr_o=0x40; stall_o=1 for 7 cycles; then instr_o=word0, stall_o=0.
//  2. Spatial hit: after test 1, addr 0x5C.
//     -> stall_o=0 same cycle; instr_o=word7 of that line; mem_req_o stays 0.
//  3. Conflict: 0x40 filled, then 0x440 (same IDX, different TAG).
//     -> miss, mem_addr_o=0x440; then 0x40 misses again.
//  4. Flush: flush_i pulsed in REQ while filling 0x80.
//     -> fill completes; the next access to 0x80 misses again.
//  5. Reset mid-REQ: assert rst_i with mem_req_o=1.
//     -> mem_req_o=0 immediately; a later mem_ack_i does not set valid; 0x40 misses.
//  6. ICACHE_STATS_EN: run tests 1-2.
//     -> miss_cnt_o=1, hit_cnt_o=2 (the post-fill fetch plus the 0x5C fetch).

Source files
------------

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache between the PC and instruction memory.
// Latency: hits return in the same cycle; a miss stalls for 3 + (ack delay) cycles.
// Backpressure: stall_o holds the PC during a miss or flush; refills use a mem_req_o/mem_ack_i handshake.
// Optional feature: define ICACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o counters.
module icache_ctrl #(
    parameter int NUM_LINES  = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic [31:0]              addr_i,
    input  logic                     flush_i,
    output logic [31:0]              instr_o,
    output logic                     stall_o,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic [LINE_WORDS*32-1:0] mem_data_i,
    input  logic                     mem_ack_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int LO    = OFF_W + 2;
    localparam int TAG_W = 32 - LO - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Per-line storage
    logic [NUM_LINES-1:0]     valid;
    logic [TAG_W-1:0]         tags  [NUM_LINES];
    logic [LINE_WORDS*32-1:0] lines [NUM_LINES];

    // Refill context
    logic [LINE_WORDS*32-1:0] fill_line;
    logic                     flush_pend;
    logic [IDX_W-1:0]         fill_idx;
    logic [TAG_W-1:0]         fill_tag;

    // Address split of the current fetch
    logic [OFF_W-1:0]         off;
    logic [IDX_W-1:0]         idx;
    logic [TAG_W-1:0]         tag;
    logic [LINE_WORDS*32-1:0] cur_line;
    logic                     is_idle;
    logic                     hit;
    logic                     serve;
    logic                     clear_all;

    assign off      = addr_i[LO-1:2];
    assign idx      = addr_i[LO+IDX_W-1:LO];
    assign tag      = addr_i[31:LO+IDX_W];
    assign cur_line = lines[idx];
    assign fill_idx = mem_addr_o[LO+IDX_W-1:LO];
    assign fill_tag = mem_addr_o[31:LO+IDX_W];

    assign is_idle  = (state == S_IDLE);
    assign hit      = req_i & valid[idx] & (tags[idx] == tag);
    // A flush cycle always stalls, so a hit in that cycle is not delivered or counted.
    assign serve    = is_idle & hit & ~flush_i;
    // A flush arriving during a miss is deferred to the FILL->IDLE edge and also kills the fresh line.
    assign clear_all = (is_idle & flush_i) |
                       ((state == S_FILL) & (flush_pend | flush_i));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (~flush_i & req_i & ~hit) state_nxt = S_REQ;
            S_REQ:   if (mem_ack_i)               state_nxt = S_FILL;
            S_FILL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs derived from state and the current lookup
    always_comb begin
        instr_o   = 32'd0;
        stall_o   = 1'b1;
        mem_req_o = (state == S_REQ);
        if (is_idle) begin
            stall_o = flush_i | (req_i & ~hit);
            if (serve) instr_o = cur_line[{off, 5'b0} +: 32];
        end
    end

    // Miss context: line address, pending flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_addr_o <= 32'd0;
            flush_pend <= 1'b0;
        end else begin
            if (is_idle & ~flush_i & req_i & ~hit)
                mem_addr_o <= {tag, idx, {LO{1'b0}}};
            if ((state == S_REQ) & flush_i)
                flush_pend <= 1'b1;
            else if (state == S_FILL)
                flush_pend <= 1'b0;
        end
    end

    // Valid bits: set on fill, cleared wholesale by a flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            valid <= '0;
        else if (clear_all)
            valid <= '0;
        else if (state == S_FILL)
            valid[fill_idx] <= 1'b1;
    end

    // Line data capture and tag/data array writes (contents are qualified by valid)
    always_ff @(posedge clk_i) begin
        if ((state == S_REQ) & mem_ack_i)
            fill_line <= mem_data_i;
        if (state == S_FILL) begin
            lines[fill_idx] <= fill_line;
            tags[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // Hit and miss statistics, free-running with natural wrap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= 32'd0;
            miss_cnt_o <= 32'd0;
        end else begin
            if (serve)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (state == S_IDLE && state_nxt == S_REQ)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule
